crossbar_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer for the 3x3 switch crossbar. Reads the head word of each

---
 rtl/crossbar_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_crossbar_rr_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 3x3 switch crossbar: one grant decision every three
// cycles (S_REQ -> S_WAIT -> S_GRANT), with independent round-robin and back-pressure per output.
module crossbar_rr_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] head_data1,
  input  logic [DATA_W-1:0] head_data2,
  input  logic [DATA_W-1:0] head_data3,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [ADDR_W-1:0] wr_addr2,
  input  logic [ADDR_W-1:0] wr_addr3,
  input  logic              out_full1,
  input  logic              out_full2,
  input  logic              out_full3,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3,
  output logic              rd_en1,
  output logic              rd_en2,
  output logic              rd_en3,
  output logic [1:0]        mux_sel1,
  output logic [1:0]        mux_sel2,
  output logic [1:0]        mux_sel3,
  output logic              out_wr1,
  output logic              out_wr2,
  output logic              out_wr3
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_GRANT} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_rd_addr [3];
  logic [2:0]        r_valid;
  logic [2:0]        r_rd_en;
  logic [2:0]        r_out_wr;
  logic [1:0]        r_mux_sel [3];
  logic [1:0]        r_rr_ptr  [3];

  logic [DATA_W-1:0] w_head    [3];
  logic [ADDR_W-1:0] w_wr_addr [3];
  logic [2:0]        w_full;
  logic [2:0]        w_req     [3];  // w_req[j][k]: input k requests output j
  logic [2:0]        w_bubble;
  logic [2:0]        w_adv;
  logic [1:0]        w_win     [3];

  assign w_head[0]    = head_data1;
  assign w_head[1]    = head_data2;
  assign w_head[2]    = head_data3;
  assign w_wr_addr[0] = wr_addr1;
  assign w_wr_addr[1] = wr_addr2;
  assign w_wr_addr[2] = wr_addr3;
  assign w_full       = {out_full3, out_full2, out_full1};

  assign rd_addr1 = r_rd_addr[0];
  assign rd_addr2 = r_rd_addr[1];
  assign rd_addr3 = r_rd_addr[2];
  assign rd_en1   = r_rd_en[0];
  assign rd_en2   = r_rd_en[1];
  assign rd_en3   = r_rd_en[2];
  assign mux_sel1 = r_mux_sel[0];
  assign mux_sel2 = r_mux_sel[1];
  assign mux_sel3 = r_mux_sel[2];
  assign out_wr1  = r_out_wr[0];
  assign out_wr2  = r_out_wr[1];
  assign out_wr3  = r_out_wr[2];

  // Search starts at the input just after the previous winner; returns 1..3, or 0 for none.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] ptr);
    pick = 2'd0;
    case (ptr)
      2'd1: begin
        if      (req[1]) pick = 2'd2;
        else if (req[2]) pick = 2'd3;
        else if (req[0]) pick = 2'd1;
      end
      2'd2: begin
        if      (req[2]) pick = 2'd3;
        else if (req[0]) pick = 2'd1;
        else if (req[1]) pick = 2'd2;
      end
      default: begin
        if      (req[0]) pick = 2'd1;
        else if (req[1]) pick = 2'd2;
        else if (req[2]) pick = 2'd3;
      end
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    w_bubble = '0;
    w_adv    = '0;
    for (int j = 0; j < 3; j++) w_req[j] = '0;

    for (int k = 0; k < 3; k++) begin
      if (r_valid[k]) begin
        if (w_head[k] == '0) begin
          w_bubble[k] = 1'b1;
        end else begin
          case (w_head[k][1:0])
            2'b01:   w_req[0][k] = 1'b1;
            2'b11:   w_req[2][k] = 1'b1;
            default: w_req[1][k] = 1'b1;  // 10 and 00 both route to output 2
          endcase
        end
      end
    end

    for (int j = 0; j < 3; j++) begin
      w_win[j] = w_full[j] ? 2'd0 : pick(w_req[j], r_rr_ptr[j]);
    end

    for (int k = 0; k < 3; k++) begin
      w_adv[k] = w_bubble[k];
      for (int j = 0; j < 3; j++) begin
        if (w_win[j] == 2'(k + 1)) w_adv[k] = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_REQ;
      r_valid  <= '0;
      r_rd_en  <= '0;
      r_out_wr <= '0;
      for (int k = 0; k < 3; k++) begin
        r_rd_addr[k] <= '0;
        r_mux_sel[k] <= 2'd0;
        r_rr_ptr[k]  <= 2'd3;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          for (int k = 0; k < 3; k++) begin
            r_valid[k] <= (r_rd_addr[k] != w_wr_addr[k]);
            r_rd_en[k] <= (r_rd_addr[k] != w_wr_addr[k]);
            r_mux_sel[k] <= 2'd0;
          end
          r_out_wr <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_rd_en <= '0;
          r_state <= S_GRANT;
        end
        S_GRANT: begin
          for (int j = 0; j < 3; j++) begin
            r_out_wr[j]  <= (w_win[j] != 2'd0);
            r_mux_sel[j] <= w_win[j];
            if (w_win[j] != 2'd0) r_rr_ptr[j] <= w_win[j];
          end
          // Winners and bubbles pop their head word; the pointer wraps naturally.
          for (int k = 0; k < 3; k++) begin
            if (w_adv[k]) r_rd_addr[k] <= r_rd_addr[k] + 1'b1;
          end
          r_state <= S_REQ;
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_rr_arbiter.sv
// Self-checking bench for crossbar_rr_arbiter: input RAMs and a queue-level reference model
// feed a per-decision scoreboard that a phase-tracking monitor drains.
module tb_crossbar_rr_arbiter;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] hd [3];
  logic [AW-1:0] wa [3];
  logic [2:0]    full_v;

  logic [AW-1:0] rd_addr1, rd_addr2, rd_addr3;
  logic          rd_en1, rd_en2, rd_en3;
  logic [1:0]    mux_sel1, mux_sel2, mux_sel3;
  logic          out_wr1, out_wr2, out_wr3;

  logic [AW-1:0] ra [3];
  logic [1:0]    msel [3];
  logic [2:0]    ren, owr;

  always #5 clk = ~clk;

  crossbar_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .head_data1(hd[0]), .head_data2(hd[1]), .head_data3(hd[2]),
    .wr_addr1(wa[0]), .wr_addr2(wa[1]), .wr_addr3(wa[2]),
    .out_full1(full_v[0]), .out_full2(full_v[1]), .out_full3(full_v[2]),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_en1(rd_en1), .rd_en2(rd_en2), .rd_en3(rd_en3),
    .mux_sel1(mux_sel1), .mux_sel2(mux_sel2), .mux_sel3(mux_sel3),
    .out_wr1(out_wr1), .out_wr2(out_wr2), .out_wr3(out_wr3)
  );

  always_comb begin
    ra[0] = rd_addr1;  ra[1] = rd_addr2;  ra[2] = rd_addr3;
    msel[0] = mux_sel1; msel[1] = mux_sel2; msel[2] = mux_sel3;
    ren = {rd_en3, rd_en2, rd_en1};
    owr = {out_wr3, out_wr2, out_wr1};
  end

  // Input RAMs with a one-cycle registered read port.
  logic [DW-1:0] mem [3][DEPTH];
  always @(posedge clk) begin
    if (rd_en1) hd[0] <= mem[0][rd_addr1];
    if (rd_en2) hd[1] <= mem[1][rd_addr2];
    if (rd_en3) hd[2] <= mem[2][rd_addr3];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected outcome of one decision; index 0..2 stands for port 1..3.
  typedef struct packed {
    logic [2:0]         valid;
    logic [2:0]         wr;
    logic [2:0][1:0]    sel;
    logic [2:0][DW-1:0] word;
    logic [2:0][AW-1:0] rda;
  } rec_t;

  rec_t exp_q [$];
  logic [1:0] obs3 [$];

  // Reference model: words written (wp) versus words consumed (cons) per input, plus last winner per output.
  int wp   [3] = '{0, 0, 0};
  int cons [3] = '{0, 0, 0};
  int rr   [3] = '{3, 3, 3};

  function automatic int dest_of(input logic [DW-1:0] w);
    if (w[1:0] == 2'b01) return 1;
    if (w[1:0] == 2'b11) return 3;
    return 2;
  endfunction

  function automatic logic [DW-1:0] gen_word(input int dest);
    logic [DW-1:0] r;
    logic [1:0]    code;
    if (dest == 0) return '0;
    r = $urandom();
    if (dest == 1)      code = 2'b01;
    else if (dest == 3) code = 2'b11;
    else                code = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b00;
    r = {r[DW-1:2], code};
    if (r == '0) r[2] = 1'b1;
    return r;
  endfunction

  task automatic write_word(input int k, input logic [DW-1:0] w);
    mem[k][wp[k] % DEPTH] = w;
    wp[k]++;
    wa[k] = AW'(wp[k] % DEPTH);
  endtask

  task automatic model_decision(input logic [2:0] full);
    rec_t          r;
    logic [DW-1:0] hw [3];
    int            want [3];
    int            c, win;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      want[k] = 0;
      hw[k]   = '0;
      if (wp[k] - cons[k] > 0) begin
        r.valid[k] = 1'b1;
        hw[k] = mem[k][cons[k] % DEPTH];
        if (hw[k] == '0) cons[k]++;
        else             want[k] = dest_of(hw[k]);
      end
    end
    for (int j = 1; j <= 3; j++) begin
      win = 0;
      if (!full[j-1]) begin
        for (int o = 1; o <= 3; o++) begin
          c = ((rr[j-1] - 1 + o) % 3) + 1;
          if (win == 0 && want[c-1] == j) win = c;
        end
      end
      if (win != 0) begin
        r.wr[j-1]   = 1'b1;
        r.sel[j-1]  = 2'(win);
        r.word[j-1] = hw[win-1];
        rr[j-1]     = win;
        cons[win-1]++;
      end
    end
    for (int k = 0; k < 3; k++) r.rda[k] = AW'(cons[k] % DEPTH);
    exp_q.push_back(r);
  endtask

  // Called #1 after the edge that entered S_REQ; returns #1 after the next such edge.
  task automatic decision(input logic [2:0] full, input logic [2:0] late);
    model_decision(full);
    full_v = full;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      if (late[k] && (wp[k] - cons[k] < 4)) write_word(k, gen_word($urandom_range(1, 3)));
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // Monitor: tracks the 3-cycle phase from reset and checks each decision against the scoreboard.
  int   ph;
  rec_t cur;
  bit   have_cur = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) ph <= 0;
    else       ph <= (ph == 2) ? 0 : ph + 1;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        have_cur = 1'b0;
      end else if (ph == 1) begin
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          have_cur = 1'b1;
          check("rd_en_wait", 64'(ren), 64'(cur.valid));
        end else begin
          have_cur = 1'b0;
        end
      end else if (ph == 2) begin
        if (have_cur) check("rd_en_grant", 64'(ren), 64'd0);
      end else begin
        if (have_cur) begin
          for (int j = 0; j < 3; j++) begin
            check($sformatf("out_wr%0d", j + 1), 64'(owr[j]), 64'(cur.wr[j]));
            check($sformatf("mux_sel%0d", j + 1), 64'(msel[j]), 64'(cur.sel[j]));
            if (cur.wr[j] && msel[j] != 2'd0)
              check($sformatf("xbar_word%0d", j + 1), 64'(hd[msel[j]-1]), 64'(cur.word[j]));
          end
          for (int k = 0; k < 3; k++)
            check($sformatf("rd_addr%0d", k + 1), 64'(ra[k]), 64'(cur.rda[k]));
          if (owr[2]) obs3.push_back(msel[2]);
          have_cur = 1'b0;
        end else begin
          check("idle_out_wr", 64'(owr), 64'd0);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] order [6];
    int         n;
    order  = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    full_v = '0;
    for (int k = 0; k < 3; k++) wa[k] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_rd_en", 64'(ren), 64'd0);
    check("reset_out_wr", 64'(owr), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset_rd_addr%0d", k + 1), 64'(ra[k]), 64'd0);
      check($sformatf("reset_mux_sel%0d", k + 1), 64'(msel[k]), 64'd0);
    end
    reset = 1'b0;

    // Reset asserted in S_WAIT while rd_en1 is high
    write_word(0, 32'h5);
    @(posedge clk); #1;
    check("t1_rd_en1_before", 64'(rd_en1), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("t1_rd_en", 64'(ren), 64'd0);
    check("t1_out_wr", 64'(owr), 64'd0);
    check("t1_rd_addr1", 64'(ra[0]), 64'd0);
    @(posedge clk); #1;
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      wp[k] = 0; cons[k] = 0; rr[k] = 3; wa[k] = '0;
    end
    reset = 1'b0;

    // Single word to out1, then the queue is empty
    write_word(0, 32'h5);
    decision(3'b000, 3'b000);
    check("t2_out_wr1", 64'(out_wr1), 64'd1);
    check("t2_mux_sel1", 64'(mux_sel1), 64'd1);
    check("t2_rd_addr1", 64'(rd_addr1), 64'd1);
    decision(3'b000, 3'b000);
    check("t2_empty_out_wr1", 64'(out_wr1), 64'd0);

    // All three inputs contend for out3
    for (int k = 0; k < 3; k++) begin
      write_word(k, gen_word(3));
      write_word(k, gen_word(3));
    end
    obs3.delete();
    repeat (6) decision(3'b000, 3'b000);
    @(negedge clk); #1;
    check("t3_grants", 64'(obs3.size()), 64'd6);
    for (int i = 0; i < 6 && i < obs3.size(); i++)
      check($sformatf("t3_order%0d", i), 64'(obs3[i]), 64'(order[i]));
    check("t3_rd_addr1", 64'(ra[0]), 64'd3);
    check("t3_rd_addr2", 64'(ra[1]), 64'd2);
    check("t3_rd_addr3", 64'(ra[2]), 64'd2);

    // Three simultaneous grants; input 2 uses destination code 00
    write_word(0, gen_word(1));
    write_word(1, 32'h0000_1230);
    write_word(2, gen_word(3));
    decision(3'b000, 3'b000);
    check("t4_out_wr", 64'(owr), 64'b111);
    check("t4_mux_sel1", 64'(mux_sel1), 64'd1);
    check("t4_mux_sel2", 64'(mux_sel2), 64'd2);
    check("t4_mux_sel3", 64'(mux_sel3), 64'd3);

    // Back-pressure on out2 for four decisions, then release
    write_word(1, gen_word(2));
    repeat (4) begin
      decision(3'b010, 3'b000);
      check("t5_blocked_out_wr2", 64'(out_wr2), 64'd0);
      check("t5_blocked_rd_addr2", 64'(rd_addr2), 64'd3);
    end
    decision(3'b000, 3'b000);
    check("t5_release_out_wr2", 64'(out_wr2), 64'd1);
    check("t5_release_rd_addr2", 64'(rd_addr2), 64'd4);

    // Long randomized run that walks input 1 up to the top of its address space
    n = 0;
    while (cons[0] < DEPTH - 1 && n < 8000) begin
      if (wp[0] - cons[0] < 2 && wp[0] < DEPTH - 1)
        write_word(0, ($urandom_range(0, 4) == 0) ? gen_word(0) : gen_word(1));
      for (int k = 1; k < 3; k++) begin
        if (wp[k] - cons[k] < 3 && $urandom_range(0, 1) == 1)
          write_word(k, ($urandom_range(0, 9) == 0) ? gen_word(0)
                      : gen_word(($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(2, 3))));
      end
      decision({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'b0},
               {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'b0});
      n++;
    end
    n = 0;
    while ((wp[1] - cons[1]) + (wp[2] - cons[2]) > 0 && n < 50) begin
      decision(3'b000, 3'b000);
      n++;
    end

    // Pointer wrap on input 1
    check("t6_rd_addr1_top", 64'(rd_addr1), 64'hFFF);
    write_word(0, gen_word(1));
    write_word(0, gen_word(1));
    check("t6_wr_addr1", 64'(wa[0]), 64'h001);
    decision(3'b000, 3'b000);
    check("t6_wrap_out_wr1", 64'(out_wr1), 64'd1);
    check("t6_wrap_rd_addr1", 64'(rd_addr1), 64'h000);
    decision(3'b000, 3'b000);
    check("t6_next_rd_addr1", 64'(rd_addr1), 64'h001);
    decision(3'b000, 3'b000);
    check("t6_empty_out_wr1", 64'(out_wr1), 64'd0);
    check("t6_empty_rd_addr1", 64'(rd_addr1), 64'h001);
    write_word(0, 32'h0);
    decision(3'b000, 3'b000);
    check("t6_bubble_out_wr1", 64'(out_wr1), 64'd0);
    check("t6_bubble_rd_addr1", 64'(rd_addr1), 64'h002);

    // Fully random traffic with back-pressure and late writes
    repeat (300) begin
      for (int k = 0; k < 3; k++) begin
        if (wp[k] - cons[k] < 3 && $urandom_range(0, 2) != 0)
          write_word(k, ($urandom_range(0, 9) == 0) ? gen_word(0) : gen_word(int'($urandom_range(1, 3))));
      end
      decision({1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)},
               {1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0)});
    end
    repeat (6) decision(3'b000, 3'b000);
    @(negedge clk); #1;
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
